// File: rtl/base_bitunswap_skid.sv
// Registered descending-to-ascending bit-order converter with a two-entry skid buffer.
// Latency 1 cycle when empty; i_r is a pure register output (~skid valid), full throughput.
module base_bitunswap_skid #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [0:width-1] o_d
);

  logic             m_v_q, m_v_d;
  logic             s_v_q, s_v_d;
  logic [width-1:0] m_d_q, m_d_d;
  logic [width-1:0] s_d_q, s_d_d;
  logic             acc;
  logic             pop;

  assign i_r = ~s_v_q;
  assign o_v = m_v_q;
  assign acc = i_v & ~s_v_q;
  assign pop = m_v_q & o_r;

  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_d_d = m_d_q;
    s_d_d = s_d_q;
    if (!m_v_q) begin
      if (acc) begin
        m_v_d = 1'b1;
        m_d_d = i_d;
      end
    end else if (pop) begin
      if (s_v_q) begin
        m_d_d = s_d_q;
        s_v_d = 1'b0;
      end else if (acc) begin
        m_d_d = i_d;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (!s_v_q && acc) begin
      s_v_d = 1'b1;
      s_d_d = i_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_d_q <= '0;
      s_d_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      m_d_q <= m_d_d;
      s_d_q <= s_d_d;
    end
  end

  // Index-for-index copy into the ascending port, which bit-reverses the packed value.
  always_comb begin
    for (int k = 0; k < width; k++) begin
      o_d[k] = m_d_q[k];
    end
  end

endmodule

// File: tb/tb_base_bitunswap_skid.sv
// Self-checking bench for base_bitunswap_skid at widths 8, 13 and 1.
module tb_base_bitunswap_skid;

  logic clk;
  logic reset;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;

  logic        iv13, ir13, ov13, or13;
  logic [12:0] id13, od13;

  logic       iv1, ir1, ov1, or1;
  logic [0:0] id1, od1;

  int checks;
  int failures;

  base_bitunswap_skid #(.width(8)) dut8 (
    .clk(clk), .reset(reset), .i_v(iv8), .i_r(ir8), .i_d(id8),
    .o_v(ov8), .o_r(or8), .o_d(od8)
  );

  base_bitunswap_skid #(.width(13)) dut13 (
    .clk(clk), .reset(reset), .i_v(iv13), .i_r(ir13), .i_d(id13),
    .o_v(ov13), .o_r(or13), .o_d(od13)
  );

  base_bitunswap_skid #(.width(1)) dut1 (
    .clk(clk), .reset(reset), .i_v(iv1), .i_r(ir1), .i_d(id1),
    .o_v(ov1), .o_r(or1), .o_d(od1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] rev13(input logic [12:0] d);
    logic [12:0] r;
    for (int k = 0; k < 13; k++) r[12-k] = d[k];
    return r;
  endfunction

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       orr;
    logic       ov;
    logic [7:0] od;
    logic       ir;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [12:0] q[$];
    logic [12:0] d;
    logic        v, r;
    int          beats;
    int          cyc;

    checks   = 0;
    failures = 0;

    // single beat, streaming, backpressure (inputs before edge, outputs after edge)
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1};
    tbl[2]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1};
    tbl[3]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h40, 1'b1};
    tbl[4]  = '{1'b1, 8'h0F, 1'b1, 1'b1, 8'hF0, 1'b1};
    tbl[5]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h88, 1'b1};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h88, 1'b0};
    tbl[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h88, 1'b0};
    tbl[10] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1};
    tbl[11] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'hCC, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hCC, 1'b1};

    reset = 1'b1;
    iv8 = 0; id8 = '0; or8 = 0;
    iv13 = 0; id13 = '0; or13 = 0;
    iv1 = 0; id1 = '0; or1 = 0;
    #2;
    chk("reset_o_v", {31'd0, ov8}, 32'd0);
    chk("reset_o_d", {24'd0, od8}, 32'd0);
    chk("reset_i_r", {31'd0, ir8}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      iv8 = tbl[i].iv; id8 = tbl[i].id; or8 = tbl[i].orr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_o_v", i), {31'd0, ov8}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_o_d", i), {24'd0, od8}, {24'd0, tbl[i].od});
      chk($sformatf("vec%0d_i_r", i), {31'd0, ir8}, {31'd0, tbl[i].ir});
    end

    // width 1 stream 1,0,1
    or1 = 1'b1; iv1 = 1'b1; id1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_b0_o_v", {31'd0, ov1}, 32'd1);
    chk("w1_b0_o_d", {31'd0, od1}, 32'd1);
    id1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_b1_o_v", {31'd0, ov1}, 32'd1);
    chk("w1_b1_o_d", {31'd0, od1}, 32'd0);
    id1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_b2_o_v", {31'd0, ov1}, 32'd1);
    chk("w1_b2_o_d", {31'd0, od1}, 32'd1);
    iv1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_idle_o_v", {31'd0, ov1}, 32'd0);

    // reset with both entries full
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'hAA;
    @(posedge clk); #1;
    id8 = 8'hBB;
    @(posedge clk); #1;
    chk("full_i_r", {31'd0, ir8}, 32'd0);
    chk("full_o_v", {31'd0, ov8}, 32'd1);
    id8 = 8'hCC;
    reset = 1'b1;
    #1;
    chk("async_rst_o_v", {31'd0, ov8}, 32'd0);
    chk("async_rst_o_d", {24'd0, od8}, 32'd0);
    chk("async_rst_i_r", {31'd0, ir8}, 32'd1);
    @(posedge clk); #1;
    chk("in_rst_o_v", {31'd0, ov8}, 32'd0);
    reset = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_o_v", i), {31'd0, ov8}, 32'd0);
    end
    iv8 = 1'b1; id8 = 8'h03;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("post_rst_beat_o_v", {31'd0, ov8}, 32'd1);
    chk("post_rst_beat_o_d", {24'd0, od8}, 32'h0C0);
    @(posedge clk); #1;

    // random traffic, width 13, scoreboard plus occupancy model
    beats = 0;
    cyc   = 0;
    iv13  = 1'b0;
    or13  = 1'b0;
    while (beats < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      chk("rnd_o_v", {31'd0, ov13}, {31'd0, (q.size() > 0)});
      chk("rnd_i_r", {31'd0, ir13}, {31'd0, (q.size() < 2)});
      if (ov13 && q.size() > 0) chk("rnd_o_d", {19'd0, od13}, {19'd0, q[0]});
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 13'($urandom);
      iv13 = v; id13 = d; or13 = r;
      if (ov13 && r && q.size() > 0) begin
        void'(q.pop_front());
        beats++;
      end
      if (v && ir13) q.push_back(rev13(d));
    end
    if (beats < 10000) begin
      failures++;
      $display("FAIL rnd_timeout actual=%0d required=10000 beats", beats);
    end
    iv13 = 1'b0;
    or13 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
